// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle processor control path: opcode map,
// ALU operation codes, FSM state encodings, datapath mux selects and the
// control output bundle.
package multicycle_control_pkg;

    // Field widths
    localparam int OPCODE_NUM_BITS = 4;
    localparam int ALU_OP_NUM_BITS = 2;
    localparam int RETIRE_CNT_BITS = 32;

    // Opcode map
    localparam logic [OPCODE_NUM_BITS-1:0] OP_ADD  = 4'd0;
    localparam logic [OPCODE_NUM_BITS-1:0] OP_SUB  = 4'd1;
    localparam logic [OPCODE_NUM_BITS-1:0] OP_LD   = 4'd2;
    localparam logic [OPCODE_NUM_BITS-1:0] OP_ST   = 4'd3;
    localparam logic [OPCODE_NUM_BITS-1:0] OP_BEQ  = 4'd4;
    localparam logic [OPCODE_NUM_BITS-1:0] OP_HALT = 4'd15;

    // ALU operations; ADD/SUB opcodes share these encodings so EXECUTE
    // can forward the low opcode bits directly.
    localparam logic [ALU_OP_NUM_BITS-1:0] ALU_ADD = 2'd0;
    localparam logic [ALU_OP_NUM_BITS-1:0] ALU_SUB = 2'd1;

    // FSM states
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_ALU_WB    = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_HALT      = 4'd9
    } state_e;

    // Datapath mux selects
    localparam logic [1:0] SRCB_REG = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    localparam logic SRCA_PC       = 1'b0;
    localparam logic SRCA_REG      = 1'b1;
    localparam logic IORD_PC       = 1'b0;
    localparam logic IORD_ALUOUT   = 1'b1;
    localparam logic PCSRC_ALU     = 1'b0;
    localparam logic PCSRC_ALUOUT  = 1'b1;
    localparam logic M2R_ALUOUT    = 1'b0;
    localparam logic M2R_MDR       = 1'b1;

    // Complete control bundle driven into the datapath
    typedef struct packed {
        logic                       pc_write;
        logic                       ir_write;
        logic                       reg_write;
        logic                       mem_read;
        logic                       mem_write;
        logic                       iord;
        logic                       mem_to_reg;
        logic                       alu_src_a;
        logic [1:0]                 alu_src_b;
        logic [ALU_OP_NUM_BITS-1:0] alu_op;
        logic                       pc_src;
        logic                       halted;
    } ctrl_t;

    // True for every opcode the machine knows how to execute
    function automatic logic opcode_legal(input logic [OPCODE_NUM_BITS-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_LD, OP_ST, OP_BEQ, OP_HALT: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// Pure combinational map from FSM state (plus the zero / mem_ready
// qualifiers and the opcode for EXECUTE's ALU op) to the control bundle.
// Everything not explicitly driven in a state stays 0.
module control_output_decode
    import multicycle_control_pkg::*;
(
    input  state_e                      state_i,
    input  logic [OPCODE_NUM_BITS-1:0]  opcode_i,
    input  logic                        zero_i,
    input  logic                        mem_ready_i,
    output ctrl_t                       ctrl_o
);

    // Per-state control decode
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                // Read instruction at PC; PC+1 is written alongside IR
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.iord      = IORD_PC;
                ctrl_o.alu_src_a = SRCA_PC;
                ctrl_o.alu_src_b = SRCB_ONE;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                // Speculatively form PC + imm into ALUOut for BEQ
                ctrl_o.alu_src_a = SRCA_PC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ST_EXECUTE: begin
                ctrl_o.alu_src_a = SRCA_REG;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = opcode_i[ALU_OP_NUM_BITS-1:0];
            end
            ST_ALU_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = M2R_ALUOUT;
            end
            ST_MEM_ADDR: begin
                ctrl_o.alu_src_a = SRCA_REG;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ST_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = IORD_ALUOUT;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = M2R_MDR;
            end
            ST_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = IORD_ALUOUT;
            end
            ST_BRANCH: begin
                // Compare A - B; taken branch loads the precomputed target
                ctrl_o.alu_src_a = SRCA_REG;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                ctrl_o.pc_write  = zero_i;
            end
            ST_HALT: begin
                ctrl_o.halted = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle processor. Holds the state register,
// the sticky illegal-opcode flag and the retired-instruction counter; the
// per-state output map lives in control_output_decode.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int RETIRE_CNT_BITS_P = RETIRE_CNT_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [OPCODE_NUM_BITS-1:0]    opcode,
    input  logic                          zero,
    input  logic                          mem_ready,
    output logic                          pc_write,
    output logic                          ir_write,
    output logic                          reg_write,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic                          iord,
    output logic                          mem_to_reg,
    output logic                          alu_src_a,
    output logic [1:0]                    alu_src_b,
    output logic [ALU_OP_NUM_BITS-1:0]    alu_op,
    output logic                          pc_src,
    output logic                          halted,
    output logic                          illegal,
    output logic [RETIRE_CNT_BITS_P-1:0]  retired
);

    state_e                        state_q, state_d;
    logic                          illegal_q, illegal_d;
    logic [RETIRE_CNT_BITS_P-1:0]  retired_q, retired_d;
    logic                          retire_evt;
    logic                          illegal_evt;
    ctrl_t                         ctrl_raw;
    ctrl_t                         ctrl;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; only FETCH, MEM_READ and MEM_WRITE wait on memory
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB: state_d = ST_EXECUTE;
                    OP_LD, OP_ST:   state_d = ST_MEM_ADDR;
                    OP_BEQ:         state_d = ST_BRANCH;
                    OP_HALT:        state_d = ST_HALT;
                    default:        state_d = ST_FETCH;
                endcase
            end
            ST_EXECUTE:   state_d = ST_ALU_WB;
            ST_ALU_WB:    state_d = ST_FETCH;
            ST_MEM_ADDR:  state_d = (opcode == OP_LD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_FETCH;
        endcase
    end

    // Retire / illegal events: an instruction completes on the edge that
    // leaves a final state; illegal opcodes are caught in DECODE.
    always_comb begin
        retire_evt = 1'b0;
        case (state_q)
            ST_ALU_WB, ST_MEM_WB, ST_BRANCH: retire_evt = 1'b1;
            ST_MEM_WRITE:                    retire_evt = mem_ready;
            default:                         retire_evt = 1'b0;
        endcase
        illegal_evt = (state_q == ST_DECODE) && !opcode_legal(opcode);
    end

    // Next values of the illegal flag and retire counter (wraps naturally)
    always_comb begin
        illegal_d = illegal_q | illegal_evt;
        retired_d = retired_q;
        if (retire_evt) begin
            retired_d = retired_q + {{(RETIRE_CNT_BITS_P-1){1'b0}}, 1'b1};
        end
    end

    // Sticky illegal flag and retired counter; reset abandons in-flight work
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    control_output_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_raw)
    );

    // Output stage: reset kills every write/read enable immediately
    always_comb begin
        ctrl = ctrl_raw;
        if (reset) begin
            ctrl.pc_write  = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
        end
    end

    assign pc_write   = ctrl.pc_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_write  = ctrl.reg_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign iord       = ctrl.iord;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign halted     = ctrl.halted;
    assign illegal    = illegal_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: a per-cycle table of
// inputs and hand-computed outputs, plus hand-written HALT/reset sequences.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, reg_write, mem_read, mem_write;
    logic        iord, mem_to_reg, alu_src_a, pc_src, halted, illegal;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en  = {pc_write, ir_write, reg_write, mem_read, mem_write}
    // sel = {iord, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src}
    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        z;
        logic        rdy;
        logic [4:0]  en;
        logic [7:0]  sel;
        logic        h;
        logic        ill;
        logic [31:0] ret;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] op, input logic z,
                                input logic rdy, input logic [4:0] en, input logic [7:0] sel,
                                input logic h, input logic ill, input logic [31:0] ret);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy;
        v.en = en; v.sel = sel; v.h = h; v.ill = ill; v.ret = ret;
        return v;
    endfunction

    task automatic check(input string name, input logic [4:0] en, input logic [7:0] sel,
                         input logic h, input logic ill, input logic [31:0] ret);
        logic [4:0] en_a;
        logic [7:0] sel_a;
        en_a  = {pc_write, ir_write, reg_write, mem_read, mem_write};
        sel_a = {iord, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};
        checks++;
        if (en_a !== en || sel_a !== sel || halted !== h || illegal !== ill || retired !== ret) begin
            errors++;
            $display("FAIL %s: got en=%b sel=%b halted=%b illegal=%b retired=%0d, want en=%b sel=%b halted=%b illegal=%b retired=%0d",
                     name, en_a, sel_a, halted, illegal, retired, en, sel, h, ill, ret);
        end
    endtask

    vec_t vecs[43];

    initial begin
        // ----- state-by-state table -----
        // reset held: FETCH selects, enables forced off
        vecs[0]  = mk(1, 0, 0, 1, 5'b00000, 8'b00001000, 0, 0, 0);
        // ADD, memory always ready
        vecs[1]  = mk(0, 0, 0, 1, 5'b11010, 8'b00001000, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 5'b00000, 8'b00010000, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 1, 5'b00000, 8'b00100000, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 5'b00100, 8'b00000000, 0, 0, 0);
        // SUB with one FETCH wait cycle
        vecs[5]  = mk(0, 1, 0, 0, 5'b00010, 8'b00001000, 0, 0, 1);
        vecs[6]  = mk(0, 1, 0, 1, 5'b11010, 8'b00001000, 0, 0, 1);
        vecs[7]  = mk(0, 1, 0, 1, 5'b00000, 8'b00010000, 0, 0, 1);
        vecs[8]  = mk(0, 1, 0, 1, 5'b00000, 8'b00100010, 0, 0, 1);
        vecs[9]  = mk(0, 1, 0, 1, 5'b00100, 8'b00000000, 0, 0, 1);
        // LD with three MEM_READ wait cycles (8 cycles total)
        vecs[10] = mk(0, 2, 0, 1, 5'b11010, 8'b00001000, 0, 0, 2);
        vecs[11] = mk(0, 2, 0, 1, 5'b00000, 8'b00010000, 0, 0, 2);
        vecs[12] = mk(0, 2, 0, 1, 5'b00000, 8'b00110000, 0, 0, 2);
        vecs[13] = mk(0, 2, 0, 0, 5'b00010, 8'b10000000, 0, 0, 2);
        vecs[14] = mk(0, 2, 0, 0, 5'b00010, 8'b10000000, 0, 0, 2);
        vecs[15] = mk(0, 2, 0, 0, 5'b00010, 8'b10000000, 0, 0, 2);
        vecs[16] = mk(0, 2, 0, 1, 5'b00010, 8'b10000000, 0, 0, 2);
        vecs[17] = mk(0, 2, 0, 1, 5'b00100, 8'b01000000, 0, 0, 2);
        // ST with one MEM_WRITE wait
        vecs[18] = mk(0, 3, 0, 1, 5'b11010, 8'b00001000, 0, 0, 3);
        vecs[19] = mk(0, 3, 0, 1, 5'b00000, 8'b00010000, 0, 0, 3);
        vecs[20] = mk(0, 3, 0, 1, 5'b00000, 8'b00110000, 0, 0, 3);
        vecs[21] = mk(0, 3, 0, 0, 5'b00001, 8'b10000000, 0, 0, 3);
        vecs[22] = mk(0, 3, 0, 1, 5'b00001, 8'b10000000, 0, 0, 3);
        // BEQ taken (zero=1 is ignored in DECODE)
        vecs[23] = mk(0, 4, 0, 1, 5'b11010, 8'b00001000, 0, 0, 4);
        vecs[24] = mk(0, 4, 1, 1, 5'b00000, 8'b00010000, 0, 0, 4);
        vecs[25] = mk(0, 4, 1, 1, 5'b10000, 8'b00100011, 0, 0, 4);
        // BEQ not taken (mem_ready low is ignored in BRANCH)
        vecs[26] = mk(0, 4, 0, 1, 5'b11010, 8'b00001000, 0, 0, 5);
        vecs[27] = mk(0, 4, 0, 1, 5'b00000, 8'b00010000, 0, 0, 5);
        vecs[28] = mk(0, 4, 0, 0, 5'b00000, 8'b00100011, 0, 0, 5);
        // illegal opcode 7, then an ADD with the flag held
        vecs[29] = mk(0, 7, 0, 1, 5'b11010, 8'b00001000, 0, 0, 6);
        vecs[30] = mk(0, 7, 0, 1, 5'b00000, 8'b00010000, 0, 0, 6);
        vecs[31] = mk(0, 0, 0, 1, 5'b11010, 8'b00001000, 0, 1, 6);
        vecs[32] = mk(0, 0, 0, 1, 5'b00000, 8'b00010000, 0, 1, 6);
        vecs[33] = mk(0, 0, 0, 1, 5'b00000, 8'b00100000, 0, 1, 6);
        vecs[34] = mk(0, 0, 0, 1, 5'b00100, 8'b00000000, 0, 1, 6);
        // ST interrupted by reset while waiting in MEM_WRITE
        vecs[35] = mk(0, 3, 0, 1, 5'b11010, 8'b00001000, 0, 1, 7);
        vecs[36] = mk(0, 3, 0, 1, 5'b00000, 8'b00010000, 0, 1, 7);
        vecs[37] = mk(0, 3, 0, 1, 5'b00000, 8'b00110000, 0, 1, 7);
        vecs[38] = mk(0, 3, 0, 0, 5'b00001, 8'b10000000, 0, 1, 7);
        vecs[39] = mk(1, 3, 0, 0, 5'b00000, 8'b10000000, 0, 1, 7);
        vecs[40] = mk(0, 15, 0, 1, 5'b11010, 8'b00001000, 0, 0, 0);
        // HALT
        vecs[41] = mk(0, 15, 0, 1, 5'b00000, 8'b00010000, 0, 0, 0);
        vecs[42] = mk(0, 15, 0, 1, 5'b00000, 8'b00000000, 1, 0, 0);

        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 43; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; opcode = vecs[i].op;
            zero = vecs[i].z;    mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d", i), vecs[i].en, vecs[i].sel, vecs[i].h, vecs[i].ill, vecs[i].ret);
        end

        // HALT holds for 100 cycles whatever the inputs do
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            opcode = 4'($urandom_range(0, 15));
            zero = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("halt_hold%0d", c), 5'b00000, 8'b00000000, 1, 0, 0);
        end

        // One-cycle reset leaves HALT
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1; opcode = 4'd0;
        #1;
        check("halt_in_reset", 5'b00000, 8'b00000000, 1, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_halt_fetch", 5'b11010, 8'b00001000, 0, 0, 0);
        @(negedge clk);
        #1;
        check("post_halt_decode", 5'b00000, 8'b00010000, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle processor. Sequences the shared 64-bit ALU, the PC/IR/register-file enables and the memory port across fetch, decode, execute, memory and write-back cycles, one instruction at a time. Takes the opcode from the instruction register and `zero` from the ALU. Drives every datapath mux select and write enable, and stalls on a single memory ready handshake.

## Interface
- `OPCODE_NUM_BITS`, 4, width of the opcode field.
- `ALU_OP_NUM_BITS`, from `params.v` (2), width of `alu_op`; encodings ADD=0, SUB=1.
- `RETIRE_CNT_BITS`, 32, width of the retired-instruction counter.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `opcode`  in  OPCODE_NUM_BITS  IR opcode field, valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read/write this cycle.
- `pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write`  out  1 each  enables.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_to_reg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  ALU A input select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B input select: 0 = register B, 1 = constant 1, 2 = sign-extended immediate, 3 = reserved.
- `alu_op`  out  ALU_OP_NUM_BITS  operation sent to the ALU.
- `pc_src`  out  1  PC input select: 0 = ALU result, 1 = ALUOut.
- `halted`  out  1  the FSM is in HALT.
- `illegal`  out  1  sticky flag, set on an undefined opcode.
- `retired`  out  RETIRE_CNT_BITS  count of completed instructions.

## Operation
- Opcode map:
  - ADD = 0, SUB = 1 (register-register).
  - LD = 2, ST = 3 (address = A + imm).
  - BEQ = 4 (taken when A − B == 0; target = PC + imm).
  - HALT = 15.
  - All other values are illegal.
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, HALT.
- Every signal not listed for a state is 0 in that state.
- FETCH:
  - `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD, `pc_src`=0.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Go to DECODE when `mem_ready`; otherwise stay.
- DECODE:
  - `alu_src_a`=0, `alu_src_b`=2, `alu_op`=ADD (precomputes the branch target into ALUOut).
  - Next state: ADD/SUB → EXECUTE; LD/ST → MEM_ADDR; BEQ → BRANCH; HALT → HALT.
  - Illegal opcode → FETCH, sets `illegal`, does not increment `retired`.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=opcode[ALU_OP_NUM_BITS-1:0]; → ALU_WB.
- ALU_WB: `reg_write`=1, `mem_to_reg`=0; → FETCH; retire.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=ADD; LD → MEM_READ, ST → MEM_WRITE.
- MEM_READ: `mem_read`=1, `iord`=1; → MEM_WB when `mem_ready`, otherwise stay.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1; → FETCH; retire.
- MEM_WRITE: `mem_write`=1, `iord`=1; → FETCH when `mem_ready` (retire), otherwise stay.
- BRANCH:
  - `alu_src_a`=1, `alu_src_b`=0, `alu_op`=SUB, `pc_src`=1, `pc_write`=`zero`.
  - → FETCH; retire whether or not the branch is taken.
- HALT:
  - All enables 0, `halted`=1.
  - Only `reset` exits this state.
- `retired` increments by exactly 1 on the edge that leaves a retiring state. It wraps to 0 after its all-ones value.

## Timing
- Reset:
  - On a sampled `reset`: state = FETCH, `illegal`=0, `retired`=0.
  - While `reset` is high, all write/read enables are forced to 0, regardless of state.
  - A reset mid-instruction abandons the instruction with no further writes; it is not retired.
  - The first cycle after reset deassertion is FETCH with `mem_read`=1.
- Outputs are decoded combinationally from the state register (Moore form). The only exceptions are the `mem_ready`/`zero` qualifiers listed above. There are no combinational paths from `opcode` to any enable.
- Latency with `mem_ready` tied to 1: ADD/SUB = 4 cycles, LD = 5, ST = 4, BEQ = 3, illegal = 2.
- Each cycle `mem_ready` is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. During such a wait, `mem_read`/`mem_write` and `iord` hold steady.
- `mem_ready` is ignored in every other state.

## Structure
- Shared package (extend `params.v`):
  - Opcode constants.
  - ALU op codes (ALU_ADD, ALU_SUB).
  - State encodings (4-bit).
  - Mux select constants for `alu_src_b`, `iord`, `pc_src`, `mem_to_reg`.
- Natural sub-module: `control_output_decode`, a pure combinational map from (state, opcode, `zero`, `mem_ready`) to the output bundle.
- The top level holds the state register, the `illegal` flag and the `retired` counter.

## Test plan
- ADD, `mem_ready`=1:
  - Required state sequence: FETCH, DECODE, EXECUTE, ALU_WB.
  - `reg_write`=1 only in cycle 4; `alu_op`=0 in EXECUTE; `retired` 0→1.
- LD with `mem_ready` low for 3 cycles in MEM_READ:
  - Required: 8 cycles total, `mem_read`=`iord`=1 steady through the wait.
  - `reg_write`=1 with `mem_to_reg`=1 exactly once.
- BEQ:
  - With `zero`=1: `pc_write`=1 and `pc_src`=1 in BRANCH.
  - With `zero`=0: `pc_write`=0.
  - Both cases: 3 cycles, `retired` incremented.
- Opcode 7 (illegal): required response is FETCH→DECODE→FETCH, `illegal`=1 and held, `retired` unchanged, no writes.
- HALT:
  - Required: `halted`=1 held for 100 cycles with all enables 0.
  - Then assert `reset` for 1 cycle: next state is FETCH, `halted`=0, `retired`=0.
- `reset` asserted in MEM_WRITE while waiting on `mem_ready`: required response is `mem_write` dropping to 0 in the same cycle, next state FETCH, and no retire.
